// File: rtl/prio_intr_pkg.sv
// Shared definitions for the priority interrupt controller: register map,
// FSM state encoding and the CURRENT register layout.
package prio_intr_pkg;

  localparam int REG_ENABLE    = 0;
  localparam int REG_MODE      = 1;
  localparam int REG_PENDING   = 2;
  localparam int REG_THRESHOLD = 3;
  localparam int REG_CURRENT   = 4;
  localparam int REG_PRI_BASE  = 8;

  localparam int CUR_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/prio_intr_arb.sv
// Combinational N-way max-priority selector; ties resolve to the lowest index.
module prio_intr_arb #(
  parameter int NUM       = 16,
  parameter int PRI_WIDTH = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic [NUM-1:0]           eligible_i,
  input  logic [NUM*PRI_WIDTH-1:0] pri_i,
  output logic                     any_eligible_o,
  output logic [ID_WIDTH-1:0]      winner_id_o
);

  logic [PRI_WIDTH-1:0] best_pri;

  // Strictly-greater compare keeps the earlier (lower) index on equal priority.
  always_comb begin
    any_eligible_o = 1'b0;
    winner_id_o    = '0;
    best_pri       = '0;
    for (int i = 0; i < NUM; i++) begin
      if (eligible_i[i] &&
          (!any_eligible_o || (pri_i[i*PRI_WIDTH +: PRI_WIDTH] > best_pri))) begin
        any_eligible_o = 1'b1;
        best_pri       = pri_i[i*PRI_WIDTH +: PRI_WIDTH];
        winner_id_o    = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/prio_intr_ctrl.sv
// APB-programmed priority interrupt controller presenting one winning source
// at a time to the processor through a valid/serviced handshake.
module prio_intr_ctrl
  import prio_intr_pkg::*;
#(
  parameter int NUM_PHES   = 16,
  parameter int PRI_WIDTH  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_PHES),
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  perror_o,
  input  logic [NUM_PHES-1:0]   intr_active_i,
  output logic                  intr_valid_o,
  output logic [ID_WIDTH-1:0]   intrt_to_be_serviced_o,
  input  logic                  intrt_serviced_i
);

  logic                  access, mapped, wr_en, rd_en, pri_hit;
  logic [ADDR_WIDTH-1:0] pri_off;
  logic [ID_WIDTH-1:0]   pri_sel;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_pwdata;

  logic [NUM_PHES-1:0]   enable_q, enable_d, mode_q, mode_d;
  logic [NUM_PHES-1:0]   pending_q, pending_d, hist_q;
  logic [NUM_PHES-1:0]   w1c, svc_clr, rise, eligible;
  logic [PRI_WIDTH-1:0]  thresh_q, thresh_d;
  logic [PRI_WIDTH-1:0]  pri_q [NUM_PHES];
  logic [PRI_WIDTH-1:0]  pri_d [NUM_PHES];
  logic [NUM_PHES*PRI_WIDTH-1:0] pri_flat;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  any_elig;
  logic [ID_WIDTH-1:0]   win_id;

  assign unused_pwdata = ^pwdata_i;

  assign access   = psel_i & penable_i;
  assign pri_off  = paddr_i - ADDR_WIDTH'(REG_PRI_BASE);
  assign pri_hit  = (paddr_i >= ADDR_WIDTH'(REG_PRI_BASE)) &&
                    (pri_off < ADDR_WIDTH'(NUM_PHES));
  assign pri_sel  = pri_off[ID_WIDTH-1:0];
  assign mapped   = pri_hit || (paddr_i <= ADDR_WIDTH'(REG_CURRENT));
  assign wr_en    = access & pwrite_i & mapped;
  assign rd_en    = access & ~pwrite_i;
  assign pready_o = access;
  assign perror_o = access & ~mapped;

  always_comb begin
    rdata = '0;
    if (pri_hit) begin
      rdata[PRI_WIDTH-1:0] = pri_q[pri_sel];
    end else begin
      case (paddr_i)
        ADDR_WIDTH'(REG_ENABLE):    rdata[NUM_PHES-1:0]  = enable_q;
        ADDR_WIDTH'(REG_MODE):      rdata[NUM_PHES-1:0]  = mode_q;
        ADDR_WIDTH'(REG_PENDING):   rdata[NUM_PHES-1:0]  = pending_q;
        ADDR_WIDTH'(REG_THRESHOLD): rdata[PRI_WIDTH-1:0] = thresh_q;
        ADDR_WIDTH'(REG_CURRENT): begin
          rdata[CUR_VALID_BIT]  = valid_q;
          rdata[ID_WIDTH-1:0]   = id_q;
        end
        default: ;
      endcase
    end
    prdata_d = rd_en ? rdata : prdata_q;
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    pri_d    = pri_q;
    w1c      = '0;
    if (wr_en) begin
      if (pri_hit) begin
        pri_d[pri_sel] = pwdata_i[PRI_WIDTH-1:0];
      end else begin
        case (paddr_i)
          ADDR_WIDTH'(REG_ENABLE):    enable_d = pwdata_i[NUM_PHES-1:0];
          ADDR_WIDTH'(REG_MODE):      mode_d   = pwdata_i[NUM_PHES-1:0];
          ADDR_WIDTH'(REG_PENDING):   w1c      = pwdata_i[NUM_PHES-1:0];
          ADDR_WIDTH'(REG_THRESHOLD): thresh_d = pwdata_i[PRI_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Edge bits: a fresh rising edge overrides any clear landing in the same cycle.
  assign rise      = intr_active_i & ~hist_q;
  assign pending_d = (mode_q & ((pending_q & ~(w1c | svc_clr)) | rise)) |
                     (~mode_q & intr_active_i);

  always_comb begin
    eligible = '0;
    pri_flat = '0;
    for (int i = 0; i < NUM_PHES; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (pri_q[i] > thresh_q);
      pri_flat[i*PRI_WIDTH +: PRI_WIDTH] = pri_q[i];
    end
  end

  prio_intr_arb #(
    .NUM       (NUM_PHES),
    .PRI_WIDTH (PRI_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) u_arb (
    .eligible_i     (eligible),
    .pri_i          (pri_flat),
    .any_eligible_o (any_elig),
    .winner_id_o    (win_id)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    svc_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          id_d    = win_id;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (intrt_serviced_i) begin
          svc_clr[id_q] = 1'b1;
          valid_d       = 1'b0;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      hist_q    <= '0;
      thresh_q  <= '0;
      for (int i = 0; i < NUM_PHES; i++) pri_q[i] <= '0;
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      id_q      <= '0;
      prdata_q  <= '0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      hist_q    <= intr_active_i;
      thresh_q  <= thresh_d;
      pri_q     <= pri_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      prdata_q  <= prdata_d;
    end
  end

  assign prdata_o               = prdata_q;
  assign intr_valid_o           = valid_q;
  assign intrt_to_be_serviced_o = id_q;

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Directed bench for prio_intr_ctrl: register map, arbitration, edge/level
// pending behaviour, service handshake and asynchronous reset.
module tb_prio_intr_ctrl;

  logic        clk;
  logic        prst;
  logic [5:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, perror;
  logic [15:0] intr_active;
  logic        intr_valid;
  logic [3:0]  intr_id;
  logic        serviced;

  int n_cmp = 0;
  int n_err = 0;

  prio_intr_ctrl dut (
    .pclk_i                 (clk),
    .prst_i                 (prst),
    .paddr_i                (paddr),
    .psel_i                 (psel),
    .penable_i              (penable),
    .pwrite_i               (pwrite),
    .pwdata_i               (pwdata),
    .prdata_o               (prdata),
    .pready_o               (pready),
    .perror_o               (perror),
    .intr_active_i          (intr_active),
    .intr_valid_o           (intr_valid),
    .intrt_to_be_serviced_o (intr_id),
    .intrt_serviced_i       (serviced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_intr(input string tag, input logic exp_v, input logic [3:0] exp_id);
    chk({tag, ".valid"}, 32'(intr_valid), 32'(exp_v));
    if (exp_v) chk({tag, ".id"}, 32'(intr_id), 32'(exp_id));
  endtask

  task automatic apb_wr(input int a, input logic [31:0] d);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'(a); pwdata = d;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 6'(a);
    @(negedge clk); penable = 1'b1;
    #1;
    chk({tag, ".rdy"}, 32'(pready), 32'd1);
    chk({tag, ".err"}, 32'(perror), 32'(exp_e));
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    chk({tag, ".data"}, prdata, exp_d);
  endtask

  task automatic service();
    @(negedge clk); serviced = 1'b1;
    @(negedge clk); serviced = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    prst = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; intr_active = '0; serviced = 1'b0;
    #1;
    chk("rst.valid", 32'(intr_valid), 32'd0);
    chk("rst.id", 32'(intr_id), 32'd0);
    chk("rst.prdata", prdata, 32'd0);
    chk("rst.pready", 32'(pready), 32'd0);
    chk("rst.perror", 32'(perror), 32'd0);
    idle(2);
    prst = 1'b1;

    // 1: every mapped register reads zero after reset
    for (int a = 0; a < 24; a++)
      if (a < 5 || a >= 8) rd_chk($sformatf("t1.reg%0d", a), a, 32'd0, 1'b0);
    rd_chk("t1.unmapped5", 5, 32'd0, 1'b1);

    // 2: level mode, priority winner then the remaining source
    apb_wr(11, 32'd5);
    apb_wr(15, 32'd9);
    apb_wr(0, 32'h88);
    apb_wr(3, 32'd0);
    rd_chk("t2.enable", 0, 32'h88, 1'b0);
    rd_chk("t2.err_rd_zero", 5, 32'd0, 1'b1);
    rd_chk("t2.pri7", 15, 32'd9, 1'b0);
    apb_wr(6, 32'hFFFF);
    rd_chk("t2.enable_after_err_wr", 0, 32'h88, 1'b0);
    @(negedge clk); intr_active = 16'h0088;
    @(negedge clk); chk_intr("t2.lat1", 1'b0, 4'd0);
    @(negedge clk); chk_intr("t2.lat2", 1'b1, 4'd7);
    rd_chk("t2.pending", 2, 32'h88, 1'b0);
    rd_chk("t2.current", 4, 32'h8000_0007, 1'b0);
    @(negedge clk); intr_active = 16'h0008; serviced = 1'b1;
    @(negedge clk); serviced = 1'b0; chk_intr("t2.svc1", 1'b0, 4'd0);
    @(negedge clk); chk_intr("t2.svc2", 1'b0, 4'd0);
    @(negedge clk); chk_intr("t2.next", 1'b1, 4'd3);
    @(negedge clk); intr_active = 16'h0000; serviced = 1'b1;
    @(negedge clk); serviced = 1'b0;
    idle(3);
    chk_intr("t2.quiet", 1'b0, 4'd0);

    // 3: equal priority resolves to the lower index
    apb_wr(10, 32'd6);
    apb_wr(17, 32'd6);
    apb_wr(0, 32'h204);
    @(negedge clk); intr_active = 16'h0204;
    idle(2);
    chk_intr("t3.tie", 1'b1, 4'd2);
    @(negedge clk); intr_active = 16'h0000; serviced = 1'b1;
    @(negedge clk); serviced = 1'b0;
    idle(3);
    chk_intr("t3.quiet", 1'b0, 4'd0);

    // 4: edge mode latch, service clear, W1C versus coincident edge
    apb_wr(12, 32'd3);
    apb_wr(1, 32'h10);
    apb_wr(0, 32'h10);
    @(negedge clk); intr_active = 16'h0010;
    @(negedge clk); intr_active = 16'h0000; chk_intr("t4.lat1", 1'b0, 4'd0);
    @(negedge clk); chk_intr("t4.lat2", 1'b1, 4'd4);
    rd_chk("t4.pending_set", 2, 32'h10, 1'b0);
    service();
    idle(3);
    rd_chk("t4.pending_svc_clr", 2, 32'h0, 1'b0);
    chk_intr("t4.no_repeat", 1'b0, 4'd0);
    @(negedge clk); intr_active = 16'h0010;
    @(negedge clk); intr_active = 16'h0000;
    idle(2);
    chk_intr("t4.present2", 1'b1, 4'd4);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'd2; pwdata = 32'h10;
    @(negedge clk); penable = 1'b1; intr_active = 16'h0010;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0; intr_active = 16'h0000;
    rd_chk("t4.set_wins", 2, 32'h10, 1'b0);
    apb_wr(2, 32'h10);
    rd_chk("t4.w1c", 2, 32'h0, 1'b0);
    chk_intr("t4.held", 1'b1, 4'd4);
    service();
    idle(3);
    chk_intr("t4.quiet", 1'b0, 4'd0);
    apb_wr(1, 32'h0);

    // 5: priority must exceed the threshold
    apb_wr(3, 32'd5);
    apb_wr(9, 32'd5);
    apb_wr(0, 32'h2);
    @(negedge clk); intr_active = 16'h0002;
    idle(4);
    chk_intr("t5.at_thresh", 1'b0, 4'd0);
    apb_wr(9, 32'd6);
    @(negedge clk); chk_intr("t5.above", 1'b1, 4'd1);
    @(negedge clk); intr_active = 16'h0000; serviced = 1'b1;
    @(negedge clk); serviced = 1'b0;
    apb_wr(3, 32'd0);
    idle(2);
    chk_intr("t5.quiet", 1'b0, 4'd0);

    // 6: held presentation ignores priority changes; async reset drops valid
    apb_wr(0, 32'h81);
    @(negedge clk); intr_active = 16'h0081;
    idle(2);
    chk_intr("t6.first", 1'b1, 4'd7);
    apb_wr(8, 32'd15);
    idle(2);
    chk_intr("t6.held", 1'b1, 4'd7);
    @(negedge clk); serviced = 1'b1;
    @(negedge clk); serviced = 1'b0; chk_intr("t6.svc1", 1'b0, 4'd0);
    @(negedge clk); chk_intr("t6.svc2", 1'b0, 4'd0);
    @(negedge clk); chk_intr("t6.next", 1'b1, 4'd0);
    @(negedge clk); prst = 1'b0;
    #1;
    chk("t6.rst_valid", 32'(intr_valid), 32'd0);
    chk("t6.rst_id", 32'(intr_id), 32'd0);
    intr_active = 16'h0000;
    @(negedge clk); prst = 1'b1;
    rd_chk("t6.enable_rst", 0, 32'd0, 1'b0);
    rd_chk("t6.pri7_rst", 15, 32'd0, 1'b0);
    rd_chk("t6.pending_rst", 2, 32'd0, 1'b0);
    chk_intr("t6.quiet", 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
